conv_mac_engine: RTL and testbench
==================================

# conv_mac_engine

Parametrised multiply-accumulate engine for the convolution datapath. Each accepted beat carries LANES data/weight pairs. The engine multiplies each pair, sums the lane products, and accumulates across BEATS consecutive beats; the default 3×3 kernel uses 3 lanes × 3 beats. After the final beat of a window it presents one accumulated result on a valid/ready output. It adds signed/unsigned operand mode, input/output handshakes with backpressure, and back-to-back windows with no idle cycles between them.

## Interface
- DW, 8, operand width of each data and weight element
- LANES, 3, pairs multiplied per beat
- BEATS, 3, beats per window; must be ≥ 2
- ACCW, 20, accumulator/result width; must be ≥ 2·DW + clog2(LANES·BEATS)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on beat 0 only
- in_valid  in  1  beat present
- in_ready  out  1  engine can accept the beat
- data  in  LANES·DW  lane i occupies bits [i·DW +: DW]
- weight  in  LANES·DW  same packing as data
- out_valid  out  1  result holds a completed window
- out_ready  in  1  downstream accepts the result
- result  out  ACCW  accumulated window sum

## Operation
- A beat is accepted when in_valid && in_ready.
- Beat counter: beat_cnt runs 0..BEATS-1 and advances only on accepted beats. It wraps from BEATS-1 to 0.
- Mode latch: on an accepted beat with beat_cnt==0, signed_mode is latched into mode_q. mode_q governs the whole window, so changes to signed_mode on later beats are ignored.
  - Beat 0 itself uses the live signed_mode value.
- Lane products are 2·DW bits wide.
  - Signed mode: operands and products are two's complement, and products are sign-extended to ACCW.
  - Unsigned mode: products are zero-extended to ACCW.
- The beat sum is the ACCW-bit sum of all lane products. It cannot overflow when the ACCW rule holds.
- Accumulator acc:
  - Beat 0: acc ← beat sum.
  - Middle beats: acc ← acc + beat sum.
  - Last beat (beat_cnt==BEATS-1): result ← acc + beat sum, out_valid ← 1, and the next window starts fresh.
- Output: result and out_valid hold stable while out_valid && !out_ready.
  - When out_valid && out_ready and no window completes that cycle, out_valid ← 0.
- in_ready = !(beat_cnt==BEATS-1 && out_valid && !out_ready).
  - Beats that do not complete a window are always accepted.
  - Only the completing beat stalls while a previous result is still pending.
  - in_ready combinationally depends on out_ready.
- Simultaneous events: if an output handshake and a window completion occur in the same cycle, result loads the new sum and out_valid stays 1.
- Reset clears beat_cnt, acc and mode_q, and sets result to 0 and out_valid to 0.
  - Reset asserted mid-window discards the partial sum.
  - Reset while out_valid=1 drops the pending result.
  - The first beat accepted after reset deasserts is beat 0.

## Timing
- Reset values: out_valid=0, result=0. in_ready=1 during and after reset.
- Latency: result and out_valid update at the clock edge that accepts the last beat, so they are visible in the following cycle.
- Throughput: one beat per cycle. A window takes BEATS cycles with no bubble between windows while out_ready=1.
- in_valid may drop between beats of a window. Gaps do not alter the result or beat_cnt.
- Data, weight and signed_mode are ignored on cycles without an accepted beat.

## Test plan
- Unsigned, all lanes data=0xFF and weight=0xFF for 3 beats, out_ready=1 → result=585225 (0x8EE09), out_valid high for exactly one cycle after the third beat.
- Signed 0x80×0x80 for all lanes and beats → result=147456 (0x24000). Then a back-to-back window of signed 0x80×0x7F → result=-146304 (0xDC480) on the next window's completion, with no idle cycle between the two windows.
- signed_mode=1 on beat 0 then 0 on beats 1–2, data=0xFF, weight=0x01 → result=-9 (0xFFFF7), since the mode change is ignored.
- Backpressure: out_ready=0 after window A (data=1, weight=1 → 9). Window B's beats 0–1 are accepted; beat 2 sees in_ready=0 and result holds 9. Raising out_ready → beat 2 is accepted in that same cycle, and result=window B's value on the next cycle with out_valid still 1.
- Gappy input: window A with in_valid toggling 1,0,1,0,0,1 → same result as the contiguous run. beat_cnt holds during gaps.
- Reset mid-window: 2 beats of 0xFF×0xFF, then rst for one cycle, then 3 beats of 1×1 → result=9, out_valid=0 during the reset cycle.

Source files
------------

// File: rtl/conv_mac_engine_if.sv
// Bus bundle for conv_mac_engine: input beat channel, output result channel.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready. The producer holds valid and its payload stable
// until that transfer. The consumer's ready may depend combinationally on
// the other channel (in_ready looks at out_ready), but a producer's valid
// never depends on its own ready.
interface conv_mac_engine_if #(
   parameter int DW    = 8,
   parameter int LANES = 3,
   parameter int ACCW  = 20
);
   logic                  signed_mode;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   data;
   logic [LANES*DW-1:0]   weight;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACCW-1:0]       result;

   // Driver / upstream side
   modport master (
      output signed_mode, in_valid, data, weight, out_ready,
      input  in_ready, out_valid, result
   );

   // Engine side
   modport slave (
      input  signed_mode, in_valid, data, weight, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/conv_mac_engine.sv
// Multiply-accumulate engine for the convolution datapath. Each accepted beat
// carries LANES data/weight pairs; their products are summed and accumulated
// over BEATS beats, and the window total is presented on the output channel.
// Operand signedness is chosen on beat 0 and held for the whole window.
module conv_mac_engine #(
   parameter int DW    = 8,
   parameter int LANES = 3,
   parameter int BEATS = 3,
   parameter int ACCW  = 20,
   localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   conv_mac_engine_if.slave       bus,
   output logic [CW-1:0]          o_dbg_beat_cnt
);

   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   logic [CW-1:0]    r_beat_cnt;
   logic [ACCW-1:0]  r_acc;
   logic             r_mode;
   logic [ACCW-1:0]  r_result;
   logic             r_out_valid;

   logic             w_first;
   logic             w_last;
   logic             w_mode;
   logic             w_in_ready;
   logic             w_accept;
   logic [ACCW-1:0]  w_lane_ext [LANES];
   logic [ACCW-1:0]  w_beat_sum;

   assign w_first = (r_beat_cnt == '0);
   assign w_last  = (r_beat_cnt == LAST_BEAT);

   // Beat 0 uses the live mode bit; later beats use the value latched on beat 0.
   assign w_mode = w_first ? bus.signed_mode : r_mode;

   // Only the window-completing beat can stall, and only while the previous
   // result is still waiting for the downstream.
   assign w_in_ready = !(w_last && r_out_valid && !bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   // Per-lane product: operands widened to 2*DW (sign- or zero-extended), so
   // the low 2*DW bits of the product are exact; then extended to ACCW.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DW-1:0]   w_d;
      logic [DW-1:0]   w_w;
      logic [2*DW-1:0] w_d_x;
      logic [2*DW-1:0] w_w_x;
      logic [2*DW-1:0] w_prod;

      assign w_d    = bus.data[gi*DW +: DW];
      assign w_w    = bus.weight[gi*DW +: DW];
      assign w_d_x  = w_mode ? {{DW{w_d[DW-1]}}, w_d} : {{DW{1'b0}}, w_d};
      assign w_w_x  = w_mode ? {{DW{w_w[DW-1]}}, w_w} : {{DW{1'b0}}, w_w};
      assign w_prod = w_d_x * w_w_x;
      assign w_lane_ext[gi] = w_mode ? {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod}
                                     : {{(ACCW-2*DW){1'b0}}, w_prod};
   end

   // Sum of all lane products for the current beat.
   always_comb begin
      w_beat_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         w_beat_sum = w_beat_sum + w_lane_ext[i];
      end
   end

   // Beat counter, mode latch, accumulator and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt  <= '0;
         r_acc       <= '0;
         r_mode      <= 1'b0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // Result consumed; a completing beat below overrides this.
         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_first) begin
               r_mode <= bus.signed_mode;
            end
            if (w_last) begin
               r_beat_cnt  <= '0;
               r_acc       <= '0;
               r_result    <= r_acc + w_beat_sum;
               r_out_valid <= 1'b1;
            end else begin
               r_beat_cnt <= r_beat_cnt + CW'(1);
               r_acc      <= w_first ? w_beat_sum : (r_acc + w_beat_sum);
            end
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.result     = r_result;
   assign o_dbg_beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine (DW=8, LANES=3, BEATS=3, ACCW=20).
// Window results are also checked by an output monitor against exp_q.
module tb_conv_mac_engine;

   localparam int DW    = 8;
   localparam int LANES = 3;
   localparam int BEATS = 3;
   localparam int ACCW  = 20;
   localparam int CW    = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   conv_mac_engine_if #(.DW(DW), .LANES(LANES), .ACCW(ACCW)) bus ();
   logic [CW-1:0] dbg_beat_cnt;

   conv_mac_engine #(.DW(DW), .LANES(LANES), .BEATS(BEATS), .ACCW(ACCW)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .o_dbg_beat_cnt (dbg_beat_cnt)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [ACCW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every result transfer must match the next expected sum.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_result", 32'(bus.result), 32'hFFFF_FFFF);
         end else begin
            check("sb_result", 32'(bus.result), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [LANES*DW-1:0] same3(input logic [DW-1:0] v);
      return {v, v, v};
   endfunction

   // Present one beat and hold it until accepted (bounded wait).
   task automatic send_beat(input logic sm, input logic [LANES*DW-1:0] d,
                            input logic [LANES*DW-1:0] w);
      int n;
      bus.signed_mode = sm;
      bus.data        = d;
      bus.weight      = w;
      bus.in_valid    = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [5:0] gap_pat;
   int         c0;
   int         exp_cnt;

   initial begin
      bus.signed_mode = 1'b0;
      bus.in_valid    = 1'b0;
      bus.data        = '0;
      bus.weight      = '0;
      bus.out_ready   = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result",    32'(bus.result),    32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      rst = 1'b0;
      idle(1);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Unsigned 0xFF x 0xFF: 9 * 65025 = 585225
      exp_q.push_back(20'h8EE09);
      for (int b = 0; b < BEATS; b++) send_beat(1'b0, same3(8'hFF), same3(8'hFF));
      check("u_ff_valid",  32'(bus.out_valid), 32'd1);
      check("u_ff_result", 32'(bus.result),    32'h8EE09);
      idle(1);
      check("u_ff_valid_one_cycle", 32'(bus.out_valid), 32'd0);

      // Signed back-to-back: (-128*-128)*9 = 147456, then (-128*127)*9 = -146304
      exp_q.push_back(20'h24000);
      exp_q.push_back(20'hDC480);
      c0 = cyc;
      for (int b = 0; b < BEATS; b++) send_beat(1'b1, same3(8'h80), same3(8'h80));
      check("s_80x80_valid",  32'(bus.out_valid), 32'd1);
      check("s_80x80_result", 32'(bus.result),    32'h24000);
      for (int b = 0; b < BEATS; b++) send_beat(1'b1, same3(8'h80), same3(8'h7F));
      check("s_80x7f_valid",  32'(bus.out_valid), 32'd1);
      check("s_80x7f_result", 32'(bus.result),    32'hDC480);
      check("b2b_cycles",     32'(cyc - c0),      32'd6);
      idle(2);

      // Mode latched on beat 0: -1 * 1 per lane, 9 lanes -> -9
      exp_q.push_back(20'hFFFF7);
      send_beat(1'b1, same3(8'hFF), same3(8'h01));
      send_beat(1'b0, same3(8'hFF), same3(8'h01));
      send_beat(1'b0, same3(8'hFF), same3(8'h01));
      check("mode_latch_result", 32'(bus.result), 32'hFFFF7);
      idle(2);

      // Distinct lanes: 1*4 + 2*5 + 3*6 = 32 per beat -> 96
      exp_q.push_back(20'd96);
      for (int b = 0; b < BEATS; b++) send_beat(1'b0, {8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4});
      check("lanes_result", 32'(bus.result), 32'd96);
      idle(2);

      // Gappy input, same window: in_valid 1,0,1,0,0,1 -> 96
      exp_q.push_back(20'd96);
      gap_pat = 6'b100101;  // bit 0 is the first cycle
      exp_cnt = 0;
      bus.signed_mode = 1'b0;
      bus.data   = {8'd3, 8'd2, 8'd1};
      bus.weight = {8'd6, 8'd5, 8'd4};
      for (int c = 0; c < 6; c++) begin
         bus.in_valid = gap_pat[c];
         // Junk operands on idle cycles must not matter
         if (!gap_pat[c]) bus.data = 24'($urandom_range(0, 24'hFFFFFF));
         else             bus.data = {8'd3, 8'd2, 8'd1};
         @(posedge clk);
         #1;
         if (gap_pat[c]) exp_cnt = (exp_cnt + 1) % BEATS;
         check("gap_beat_cnt", 32'(dbg_beat_cnt), 32'(exp_cnt));
      end
      bus.in_valid = 1'b0;
      check("gap_valid",  32'(bus.out_valid), 32'd1);
      check("gap_result", 32'(bus.result),    32'd96);
      idle(2);

      // Backpressure: A = 9 held while B's last beat stalls; B = 2*1*9 = 18
      exp_q.push_back(20'd9);
      exp_q.push_back(20'd18);
      bus.out_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) send_beat(1'b0, same3(8'd1), same3(8'd1));
      check("bp_a_result", 32'(bus.result), 32'd9);
      send_beat(1'b0, same3(8'd2), same3(8'd1));
      send_beat(1'b0, same3(8'd2), same3(8'd1));
      check("bp_b_beat_cnt", 32'(dbg_beat_cnt), 32'd2);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("bp_stall_in_ready", 32'(bus.in_ready),  32'd0);
      check("bp_hold_result",    32'(bus.result),    32'd9);
      check("bp_hold_valid",     32'(bus.out_valid), 32'd1);
      @(negedge clk);
      check("bp_stall2_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold2_result",    32'(bus.result),   32'd9);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_b_result",  32'(bus.result),    32'd18);
      check("bp_b_valid",   32'(bus.out_valid), 32'd1);
      check("bp_b_cnt",     32'(dbg_beat_cnt),  32'd0);
      idle(1);
      check("bp_drained_valid", 32'(bus.out_valid), 32'd0);
      idle(1);

      // Reset mid-window discards the partial 0xFF x 0xFF sum
      exp_q.push_back(20'd9);
      send_beat(1'b0, same3(8'hFF), same3(8'hFF));
      send_beat(1'b0, same3(8'hFF), same3(8'hFF));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
      check("mid_rst_result",   32'(bus.result),    32'd0);
      check("mid_rst_beat_cnt", 32'(dbg_beat_cnt), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
      rst = 1'b0;
      for (int b = 0; b < BEATS; b++) send_beat(1'b0, same3(8'd1), same3(8'd1));
      check("after_rst_result", 32'(bus.result), 32'd9);
      idle(3);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
